// File: rtl/spi_slv_ctrl_pkg.sv
// Shared definitions for the SPI slave controller.
// Holds the frame FSM state type and the header field layout.
// Header word layout: rxd[1:0] = destination channel, rxd[7:2] = payload length.
package spi_slv_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StPayload,
      StDiscard
   } state_e;

   localparam int unsigned CH_LSB  = 0;
   localparam int unsigned CH_W    = 2;
   localparam int unsigned LEN_LSB = 2;
   localparam int unsigned LEN_W   = 6;

endpackage

// File: rtl/spi_slv_ctrl_fifo.sv
// Payload buffer for the SPI slave controller.
// Synchronous FIFO with same-cycle push/pop. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise it is ignored.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, wdata_i   write request and entry
//   pop_i             read request (ignored when empty)
//   rdata_o           head entry, zero when empty
//   full_o, empty_o   occupancy flags
module spi_slv_ctrl_fifo #(
   parameter int unsigned W     = 35,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: rdata_o is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/spi_slv_ctrl.sv
// SPI slave frame controller.
// Parses a header word (channel, length) after slave select falls, routes the following
// payload words into a FIFO tagged with channel and last flag, and flags overflow,
// short frames (ss released early) and long frames (extra words).
// Optional macro SPI_SLV_CTRL_STATS_EN adds a 16-bit completed-frame counter (frame_cnt).
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_en, cfg_bpw             requested enable / bits-per-word
//   spi_en, spi_bpw             datapath config, only updated while idle
//   ss, rxd, rxd_vld            slave select (active-low), received word, word strobe
//   out_data/ch/last/vld/rdy    routed payload stream
//   busy                        frame in progress or FIFO non-empty
//   err_ovf/short/long, err_clr sticky errors and their clear
//   frame_cnt                   completed frames (SPI_SLV_CTRL_STATS_EN only)
module spi_slv_ctrl
   import spi_slv_ctrl_pkg::*;
#(
   parameter int unsigned DW         = 32,
   parameter int unsigned LOG2_DW    = 5,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_en,
   input  logic [LOG2_DW-1:0] cfg_bpw,
   output logic               spi_en,
   output logic [LOG2_DW-1:0] spi_bpw,
   input  logic               ss,
   input  logic [DW-1:0]      rxd,
   input  logic               rxd_vld,
   output logic [DW-1:0]      out_data,
   output logic [1:0]         out_ch,
   output logic               out_last,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic               busy,
   output logic               err_ovf,
   output logic               err_short,
   output logic               err_long,
`ifdef SPI_SLV_CTRL_STATS_EN
   output logic [15:0]        frame_cnt,
`endif
   input  logic               err_clr
);

   localparam int unsigned EW = DW + 3;

   state_e             state_q, state_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               spi_en_q, spi_en_d;
   logic [LOG2_DW-1:0] spi_bpw_q, spi_bpw_d;
   logic               err_ovf_q, err_short_q, err_long_q;
   logic               set_ovf, set_short, set_long;
   logic               push_req, push_last, push_ok, pop;
   logic               fifo_full, fifo_empty;
   logic [EW-1:0]      fifo_rdata;
   logic [LEN_W-1:0]   hdr_len;

   assign hdr_len = rxd[LEN_LSB +: LEN_W];
   assign pop     = out_vld && out_rdy;
   assign push_ok = push_req && (!fifo_full || pop);

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      rem_d     = rem_q;
      spi_en_d  = spi_en_q;
      spi_bpw_d = spi_bpw_q;
      push_req  = 1'b0;
      push_last = 1'b0;
      set_ovf   = 1'b0;
      set_short = 1'b0;
      set_long  = 1'b0;

      unique case (state_q)
         StIdle: begin
            spi_en_d  = cfg_en;
            spi_bpw_d = cfg_bpw;
            if (!ss && cfg_en) state_d = StHdr;
         end
         StHdr: begin
            if (rxd_vld) begin
               ch_d = rxd[CH_LSB +: CH_W];
               if (hdr_len == '0) begin
                  state_d = StDiscard;
               end else begin
                  rem_d   = hdr_len;
                  state_d = StPayload;
               end
            end
         end
         StPayload: begin
            if (rxd_vld) begin
               push_req  = 1'b1;
               push_last = (rem_q == LEN_W'(1));
               set_ovf   = !push_ok;
               // A dropped word still consumes its slot in the frame.
               rem_d     = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = StDiscard;
            end
            // A last word arriving with ss release completes the frame, so it is not short.
            if (ss && !(rxd_vld && rem_q == LEN_W'(1))) set_short = 1'b1;
         end
         StDiscard: begin
            if (rxd_vld) set_long = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // Word handling above happens first; ss release then overrides the next state.
      if (state_q != StIdle && ss) state_d = StIdle;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ch_q        <= '0;
         rem_q       <= '0;
         spi_en_q    <= 1'b0;
         spi_bpw_q   <= '0;
         err_ovf_q   <= 1'b0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         rem_q       <= rem_d;
         spi_en_q    <= spi_en_d;
         spi_bpw_q   <= spi_bpw_d;
         // Set wins over a same-cycle clear.
         err_ovf_q   <= set_ovf   || (err_ovf_q   && !err_clr);
         err_short_q <= set_short || (err_short_q && !err_clr);
         err_long_q  <= set_long  || (err_long_q  && !err_clr);
      end
   end

`ifdef SPI_SLV_CTRL_STATS_EN
   logic [15:0] frame_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
      end else if (push_ok && push_last) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   spi_slv_ctrl_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_ok),
      .wdata_i ({rxd, ch_q, push_last}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_data  = fifo_rdata[EW-1:3];
   assign out_ch    = fifo_rdata[2:1];
   assign out_last  = fifo_rdata[0];
   assign out_vld   = !fifo_empty;
   assign busy      = (state_q != StIdle) || !fifo_empty;
   assign spi_en    = spi_en_q;
   assign spi_bpw   = spi_bpw_q;
   assign err_ovf   = err_ovf_q;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;

endmodule

// File: tb/tb_spi_slv_ctrl.sv
// Self-checking bench for spi_slv_ctrl: directed frames, a scoreboard of expected
// payload entries and a monitor that checks each accepted output beat.
module tb_spi_slv_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_en;
   logic [4:0]  cfg_bpw;
   logic        spi_en;
   logic [4:0]  spi_bpw;
   logic        ss;
   logic [31:0] rxd;
   logic        rxd_vld;
   logic [31:0] out_data;
   logic [1:0]  out_ch;
   logic        out_last;
   logic        out_vld;
   logic        out_rdy;
   logic        busy;
   logic        err_ovf, err_short, err_long, err_clr;
`ifdef SPI_SLV_CTRL_STATS_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [34:0] sb[$];

   always #5 clk = ~clk;

   spi_slv_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_en    (cfg_en),
      .cfg_bpw   (cfg_bpw),
      .spi_en    (spi_en),
      .spi_bpw   (spi_bpw),
      .ss        (ss),
      .rxd       (rxd),
      .rxd_vld   (rxd_vld),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_last  (out_last),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .busy      (busy),
      .err_ovf   (err_ovf),
      .err_short (err_short),
      .err_long  (err_long),
`ifdef SPI_SLV_CTRL_STATS_EN
      .frame_cnt (frame_cnt),
`endif
      .err_clr   (err_clr)
   );

   // Monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge clk) begin
      if (out_vld && out_rdy) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat: unexpected data=%h ch=%0d last=%0d", out_data, out_ch, out_last);
         end else begin
            logic [34:0] exp;
            exp = sb.pop_front();
            if ({out_data, out_ch, out_last} !== exp) begin
               errors++;
               $display("FAIL beat: got data=%h ch=%0d last=%0d want data=%h ch=%0d last=%0d",
                        out_data, out_ch, out_last, exp[34:3], exp[2:1], exp[0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle word strobe; optionally records the expected output entry.
   task automatic word(input logic [31:0] d, input bit exp, input logic [1:0] c, input bit l);
      rxd     = d;
      rxd_vld = 1'b1;
      if (exp) sb.push_back({d, c, l});
      tick();
      rxd_vld = 1'b0;
   endtask

   task automatic end_frame();
      ss = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1; cfg_en = 1'b1; cfg_bpw = 5'd8; ss = 1'b1;
      rxd = '0; rxd_vld = 1'b0; out_rdy = 1'b1; err_clr = 1'b0;
      repeat (3) tick();
      // Reset state
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_spi_en", 32'(spi_en), 32'd0);
      chk("rst_spi_bpw", 32'(spi_bpw), 32'd0);
      chk("rst_errs", 32'({err_ovf, err_short, err_long}), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_spi_bpw", 32'(spi_bpw), 32'd8);
      chk("idle_spi_en", 32'(spi_en), 32'd1);

      // Frame ch1 len3
      ss = 1'b0; tick();
      word(32'h0000_000D, 1'b0, 2'd0, 1'b0);
      word(32'hAAAA_0001, 1'b1, 2'd1, 1'b0);
      word(32'hBBBB_0002, 1'b1, 2'd1, 1'b0);
      word(32'hCCCC_0003, 1'b1, 2'd1, 1'b1);
      end_frame();
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_errs", 32'({err_ovf, err_short, err_long}), 32'd0);

      // Frame ch2 len2 with one extra word
      ss = 1'b0; tick();
      word(32'h0000_000A, 1'b0, 2'd0, 1'b0);
      word(32'h1111_1111, 1'b1, 2'd2, 1'b0);
      word(32'h2222_2222, 1'b1, 2'd2, 1'b1);
      word(32'h3333_3333, 1'b0, 2'd0, 1'b0);
      chk("t2_err_long", 32'(err_long), 32'd1);
      end_frame();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t2_err_long_clr", 32'(err_long), 32'd0);

      // Frame ch1 len4 cut short after 2 words
      ss = 1'b0; tick();
      word(32'h0000_0011, 1'b0, 2'd0, 1'b0);
      word(32'h4444_0001, 1'b1, 2'd1, 1'b0);
      word(32'h4444_0002, 1'b1, 2'd1, 1'b0);
      ss = 1'b1; tick();
      chk("t3_busy_idle", 32'(busy), 32'd0);
      chk("t3_err_short", 32'(err_short), 32'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      chk("t3_err_short_clr", 32'(err_short), 32'd0);

      // Overflow: ch0 len6 with out_rdy low, last word pushed with a same-cycle pop
      out_rdy = 1'b0;
      ss = 1'b0; tick();
      word(32'h0000_0018, 1'b0, 2'd0, 1'b0);
      word(32'h5555_0001, 1'b1, 2'd0, 1'b0);
      chk("t4_first_out", out_data, 32'h5555_0001);
      word(32'h5555_0002, 1'b1, 2'd0, 1'b0);
      word(32'h5555_0003, 1'b1, 2'd0, 1'b0);
      word(32'h5555_0004, 1'b1, 2'd0, 1'b0);
      chk("t4_ovf_before", 32'(err_ovf), 32'd0);
      word(32'h5555_0005, 1'b0, 2'd0, 1'b0);
      chk("t4_err_ovf", 32'(err_ovf), 32'd1);
      chk("t4_head_stable", out_data, 32'h5555_0001);
      out_rdy = 1'b1;
      word(32'h5555_0006, 1'b1, 2'd0, 1'b1);
      end_frame();
      repeat (4) tick();
      chk("t4_drained", 32'(busy), 32'd0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // bpw change mid-frame, then reset mid-PAYLOAD
      ss = 1'b0; tick();
      word(32'h0000_0008, 1'b0, 2'd0, 1'b0);
      cfg_bpw = 5'd16;
      tick();
      chk("t5_bpw_hold", 32'(spi_bpw), 32'd8);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_bpw", 32'(spi_bpw), 32'd0);
      chk("t5_rst_errs", 32'({err_ovf, err_short, err_long}), 32'd0);
      ss = 1'b1; tick();
      chk("t5_bpw_new", 32'(spi_bpw), 32'd16);
      chk("t5_no_short", 32'(err_short), 32'd0);

      // Three complete len1 frames on channel 3
      for (int f = 0; f < 3; f++) begin
         ss = 1'b0; tick();
         word(32'h0000_0007, 1'b0, 2'd0, 1'b0);
         word(32'h7000_0000 + 32'(f), 1'b1, 2'd3, 1'b1);
         end_frame();
      end
`ifdef SPI_SLV_CTRL_STATS_EN
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd3);
`endif

      // Bounded drain of anything still expected
      for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
